// File: rtl/rysy_mem.sv
// Memory responder for rysy_core: byte-writable word RAM plus a small I/O window
// holding a GPIO register and a free-running timer with compare/pending interrupt.
module rysy_mem #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic [7:0]  gpio_out,
    output logic        irq_timer
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] SEL_GPIO     = 2'd0;
    localparam logic [1:0] SEL_MTIME    = 2'd1;
    localparam logic [1:0] SEL_MTIMECMP = 2'd2;
    localparam logic [1:0] SEL_STATUS   = 2'd3;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    logic [31:0]       mem_r [DEPTH];
    logic [31:0]       rdata_r;
    logic [7:0]        gpio_r;
    logic [31:0]       mtime_r;
    logic [31:0]       mtimecmp_r;
    logic              pending_r;

    logic [ADDR_W-1:0] word_idx_s;
    logic              ram_sel_s;
    logic              io_hit_s;
    logic              ram_wr_s;
    logic              wr_gpio_s;
    logic              wr_mtime_s;
    logic              wr_cmp_s;
    logic              wr_status_s;
    logic [7:0]        gpio_nxt_s;
    logic [31:0]       mtime_nxt_s;
    logic [31:0]       cmp_nxt_s;
    logic              pending_nxt_s;
    logic [31:0]       rd_nxt_s;
    logic              unused_s;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign unused_s = ^addr[1:0];

    // Address decode and per-target write strobes.
    always_comb begin
        word_idx_s  = addr[ADDR_W+1:2];
        ram_sel_s   = ~addr[31];
        io_hit_s    = addr[31] && (addr[30:4] == 27'd0);
        ram_wr_s    = we && ram_sel_s;
        wr_gpio_s   = we && io_hit_s && (addr[3:2] == SEL_GPIO);
        wr_mtime_s  = we && io_hit_s && (addr[3:2] == SEL_MTIME) && (be != 4'd0);
        wr_cmp_s    = we && io_hit_s && (addr[3:2] == SEL_MTIMECMP);
        wr_status_s = we && io_hit_s && (addr[3:2] == SEL_STATUS);
    end

    // Next-state of the I/O registers; a bus write to MTIME overrides the increment.
    always_comb begin
        gpio_nxt_s    = gpio_r;
        mtime_nxt_s   = mtime_r + 32'd1;
        cmp_nxt_s     = mtimecmp_r;
        pending_nxt_s = pending_r;
        if (wr_gpio_s && be[0]) begin
            gpio_nxt_s = wdata[7:0];
        end else begin
            gpio_nxt_s = gpio_r;
        end
        if (wr_mtime_s) begin
            mtime_nxt_s = merge_bytes(mtime_r, wdata, be);
        end else begin
            mtime_nxt_s = mtime_r + 32'd1;
        end
        if (wr_cmp_s) begin
            cmp_nxt_s = merge_bytes(mtimecmp_r, wdata, be);
        end else begin
            cmp_nxt_s = mtimecmp_r;
        end
        // A match in the same cycle as a clear keeps the flag set.
        if (mtime_r == mtimecmp_r) begin
            pending_nxt_s = 1'b1;
        end else if (wr_status_s && be[0] && wdata[0]) begin
            pending_nxt_s = 1'b0;
        end else begin
            pending_nxt_s = pending_r;
        end
    end

    // Read mux; sampled into rdata_r before any same-cycle write lands (read-first).
    always_comb begin
        rd_nxt_s = 32'd0;
        if (ram_sel_s) begin
            rd_nxt_s = mem_r[word_idx_s];
        end else if (io_hit_s) begin
            case (addr[3:2])
                SEL_GPIO:     rd_nxt_s = {24'd0, gpio_r};
                SEL_MTIME:    rd_nxt_s = mtime_r;
                SEL_MTIMECMP: rd_nxt_s = mtimecmp_r;
                SEL_STATUS:   rd_nxt_s = {31'd0, pending_r};
                default:      rd_nxt_s = 32'd0;
            endcase
        end else begin
            rd_nxt_s = 32'd0;
        end
    end

    // I/O registers and read-data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r    <= NOP_INSN;
            gpio_r     <= 8'd0;
            mtime_r    <= 32'd0;
            mtimecmp_r <= 32'hFFFF_FFFF;
            pending_r  <= 1'b0;
        end else begin
            rdata_r    <= rd_nxt_s;
            gpio_r     <= gpio_nxt_s;
            mtime_r    <= mtime_nxt_s;
            mtimecmp_r <= cmp_nxt_s;
            pending_r  <= pending_nxt_s;
        end
    end

    // RAM array: contents survive reset, but a write during reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && ram_wr_s) begin
            mem_r[word_idx_s] <= merge_bytes(mem_r[word_idx_s], wdata, be);
        end
    end

    assign rdata     = rdata_r;
    assign gpio_out  = gpio_r;
    assign irq_timer = pending_r;

endmodule

// File: doc/rysy_mem.md
# rysy_mem

Memory responder for the rysy_core data/instruction port. It answers the core's `addr`/`wdata`/`we`/`be` requests with registered `rdata`, and holds a byte-writable word RAM plus a small memory-mapped I/O region. The I/O region contains an 8-bit GPIO output register and a free-running timer with compare and a pending interrupt. The block sits directly opposite rysy_core at the top level and is the only slave on that port.

## Interface
- `ADDR_W`, 10: RAM word-address width (RAM depth = 2^ADDR_W 32-bit words).
- `clk` input 1: single clock; everything is sampled on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `addr` input 32: byte address from the core; bits [1:0] are ignored.
- `wdata` input 32: write data, byte lanes aligned to `be`.
- `we` input 1: write strobe for the current cycle.
- `be` input 4: byte enables; bit n enables `wdata[8n+7:8n]`.
- `rdata` output 32: registered read data for the request of the previous cycle.
- `gpio_out` output 8: GPIO register contents.
- `irq_timer` output 1: timer pending flag.

## Operation
- Address decode:
  - `addr[31]` = 0 selects RAM at word index `addr[ADDR_W+1:2]`. Higher address bits are ignored, so addresses alias and wrap.
  - `addr[31]` = 1 selects I/O, decoded on `addr[3:2]` only when `addr[30:4]` = 0. Any other I/O address is unmapped.
- I/O registers:
  - 0x8000_0000 GPIO: read/write, bits [7:0]; upper bits read 0.
  - 0x8000_0004 MTIME: 32-bit counter, read/write.
  - 0x8000_0008 MTIMECMP: read/write.
  - 0x8000_000C STATUS: bit0 = pending, write 1 to clear; other bits read 0.
- Writes:
  - A write occurs only when `we`=1, and only on the bytes whose `be` bit is 1.
  - `we`=1 with `be`=0 changes nothing.
  - Partial writes apply per byte to RAM, GPIO (lane 0 only), MTIME and MTIMECMP.
- Reads:
  - Every cycle, `rdata` is loaded with the content of the addressed location, regardless of `we`.
  - A read and write to the same location in the same cycle returns the old value (read-first).
  - Unmapped I/O reads return 0 and writes to it are ignored.
- Timer:
  - MTIME increments by 1 every cycle and wraps 0xFFFF_FFFF → 0.
  - A bus write to MTIME takes priority over the increment on that cycle; unwritten bytes keep their pre-increment value.
- Pending flag:
  - Sets on the cycle after MTIME equals MTIMECMP; the comparison uses the current registered values.
  - Cleared by a write with `be[0]`=1 and `wdata[0]`=1 to STATUS.
  - If set and clear happen in the same cycle, set wins.
  - `irq_timer` = pending.
- Reset values:
  - `rdata` = 0x0000_0013 (NOP), so the core sees a NOP on its first fetch.
  - `gpio_out` = 0, MTIME = 0, MTIMECMP = 0xFFFF_FFFF, pending = 0, `irq_timer` = 0.
  - RAM contents are not affected by reset.
- Reset mid-operation: a write presented in the reset cycle is discarded, for both RAM and I/O. The cycle after reset deasserts behaves as a normal cycle.

## Timing
- Read latency is 1 cycle. `addr` sampled at edge N gives `rdata` valid after edge N, stable until edge N+1.
- Writes take effect at the sampling edge. A read of the same word at edge N+1 returns the new data after edge N+1.
- There is no handshake or wait state: one request is accepted per cycle, back-to-back, indefinitely.
- MTIME read at edge N returns the value held before edge N's increment.
- With MTIMECMP = K written at least 2 cycles earlier, `irq_timer` rises the edge after MTIME holds K.

## Test plan
- Reset then idle:
  - Required: `rdata`=0x0000_0013, `gpio_out`=0 and `irq_timer`=0 during and after reset.
  - Required: MTIME reads 0 then counts up.
- Byte-enable write:
  - Stimulus: write 0xAABBCCDD to 0x0000_0010 with `be`=1111, then 0x11223344 with `be`=0101.
  - Required: a read of 0x10 returns 0xAA22CC44. A write with `be`=0000 leaves it unchanged.
- Read-first collision:
  - Stimulus: word 0x20 holds 0x1; write 0x2 to 0x20 with a read of 0x20 in the same cycle.
  - Required: next-cycle `rdata`=0x1; the following read returns 0x2. Also check that 0x0000_1020 aliases 0x20 for `ADDR_W`=10.
- I/O decode:
  - Stimulus: write 0x1A5 to GPIO.
  - Required: `gpio_out`=0xA5 and GPIO read = 0x0000_00A5. Reads of 0x8000_0010 and 0x9000_0000 return 0; writes there change nothing.
- Timer interrupt:
  - Stimulus: MTIME=0, MTIMECMP=20.
  - Required: `irq_timer` rises the edge after MTIME=20.
  - Stimulus: write 1 to STATUS.
  - Required: `irq_timer` drops.
  - Stimulus: write MTIME=0xFFFF_FFFE.
  - Required: MTIME wraps to 0.
  - Stimulus: clear in the same cycle as a match.
  - Required: pending stays 1.
- Reset mid-write:
  - Stimulus: assert `rst` with `we`=1 to 0x30 and to GPIO.
  - Required: RAM word 0x30 and `gpio_out` unchanged from before the write (GPIO reset to 0); `rdata`=0x0000_0013.
